// File: rtl/ddr_cmd_decoder.sv
// ddr_cmd_decoder: turns one rank's raw DDR4 command/address pins into
// registered one-cycle per-bank and rank-wide strobes, and tracks open
// banks, per-bank active rows and the rank power state driven by CKE.
// There is no valid/ready handshake: a command is consumed on the edge
// where it is sampled and every result appears exactly one cycle later.
module ddr_cmd_decoder #(
  parameter  int BGWIDTH   = 2,
  parameter  int BAWIDTH   = 2,
  parameter  int ADDRWIDTH = 17,
  localparam int BIW       = BGWIDTH + BAWIDTH,
  localparam int NB        = 1 << BIW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cke,
  input  logic                 cs_n,
  input  logic                 act_n,
  input  logic [BGWIDTH-1:0]   bg,
  input  logic [BAWIDTH-1:0]   ba,
  input  logic [ADDRWIDTH-1:0] A,
  output logic [NB-1:0]        ACT,
  output logic [NB-1:0]        RD,
  output logic [NB-1:0]        RDA,
  output logic [NB-1:0]        WR,
  output logic [NB-1:0]        WRA,
  output logic [NB-1:0]        PR,
  output logic [NB-1:0]        PRA,
  output logic                 REF,
  output logic                 SRF,
  output logic                 PD,
  output logic                 PDX,
  output logic                 CKEH,
  output logic                 CKEL,
  output logic                 MRW,
  output logic [BIW-1:0]       bankidx,
  output logic [ADDRWIDTH-1:0] rowaddr,
  output logic [9:0]           coladdr,
  output logic [NB-1:0]        openbanks,
  output logic [1:0]           pstate,
  output logic                 cmd_err
);

  typedef enum logic [1:0] {
    PS_ACTIVE  = 2'd0,
    PS_PWRDN   = 2'd1,
    PS_SELFREF = 2'd2
  } pstate_t;

  // Registered state and outputs
  pstate_t              r_state;
  logic                 r_cke_q;
  logic [NB-1:0]        r_act, r_rd, r_rda, r_wr, r_wra, r_pr, r_pra;
  logic                 r_ref, r_srf, r_pd, r_pdx, r_ckeh, r_ckel, r_mrw, r_err;
  logic [BIW-1:0]       r_bankidx;
  logic [ADDRWIDTH-1:0] r_rowaddr;
  logic [9:0]           r_coladdr;
  logic [NB-1:0]        r_openbanks;
  logic [ADDRWIDTH-1:0] r_row [NB];

  // Decode helpers
  logic                 w_fall, w_rise, w_valid, w_idle, w_is_ref;
  logic [2:0]           w_op;
  logic [BIW-1:0]       w_bank;

  // Power FSM next-state / pulses
  pstate_t              w_state_nxt;
  logic                 w_srf, w_pd, w_pdx, w_ckeh, w_ckel, w_pwr_err, w_exec;

  // Command decode next values
  logic [NB-1:0]        w_act, w_rd, w_rda, w_wr, w_wra, w_pr, w_pra;
  logic                 w_ref, w_mrw, w_cmd_err, w_row_we;
  logic [BIW-1:0]       w_bankidx_nxt;
  logic [ADDRWIDTH-1:0] w_rowaddr_nxt;
  logic [9:0]           w_coladdr_nxt;
  logic [NB-1:0]        w_open_nxt;

  // CKE edges are seen against the registered copy; a command is only
  // legal while the previous-cycle CKE was high.
  assign w_fall   = r_cke_q & ~cke;
  assign w_rise   = ~r_cke_q & cke;
  assign w_valid  = ~cs_n & r_cke_q;
  assign w_op     = A[ADDRWIDTH-1 -: 3];
  assign w_bank   = {bg, ba};
  assign w_idle   = ~w_valid | (act_n & (w_op == 3'b111));
  assign w_is_ref = w_valid & act_n & (w_op == 3'b001);

  // Power-state next-state logic; commands only execute in ACTIVE without a CKE fall
  always_comb begin
    w_state_nxt = r_state;
    w_srf       = 1'b0;
    w_pd        = 1'b0;
    w_pdx       = 1'b0;
    w_ckeh      = 1'b0;
    w_ckel      = 1'b0;
    w_pwr_err   = 1'b0;
    w_exec      = 1'b0;
    case (r_state)
      PS_ACTIVE: begin
        if (w_fall) begin
          w_ckel = 1'b1;
          if (w_is_ref && (r_openbanks == '0)) begin
            w_state_nxt = PS_SELFREF;
            w_srf       = 1'b1;
          end else begin
            // Any real command riding a CKE fall is dropped and flagged
            w_state_nxt = PS_PWRDN;
            w_pd        = 1'b1;
            w_pwr_err   = ~w_idle;
          end
        end else begin
          w_exec = 1'b1;
        end
      end
      PS_PWRDN: begin
        if (w_rise) begin
          w_state_nxt = PS_ACTIVE;
          w_pdx       = 1'b1;
          w_ckeh      = 1'b1;
        end
      end
      PS_SELFREF: begin
        if (w_rise) begin
          w_state_nxt = PS_ACTIVE;
          w_ckeh      = 1'b1;
        end
      end
      default: w_state_nxt = PS_ACTIVE;
    endcase
  end

  // Command decode and bank bookkeeping for the current cycle
  always_comb begin
    w_act         = '0;
    w_rd          = '0;
    w_rda         = '0;
    w_wr          = '0;
    w_wra         = '0;
    w_pr          = '0;
    w_pra         = '0;
    w_ref         = 1'b0;
    w_mrw         = 1'b0;
    w_cmd_err     = 1'b0;
    w_row_we      = 1'b0;
    w_bankidx_nxt = r_bankidx;
    w_rowaddr_nxt = r_rowaddr;
    w_coladdr_nxt = r_coladdr;
    w_open_nxt    = r_openbanks;
    if (w_exec && w_valid) begin
      if (!act_n) begin
        // ACT to an open bank is forwarded as-is (RowClone downstream)
        w_act[w_bank]      = 1'b1;
        w_open_nxt[w_bank] = 1'b1;
        w_row_we           = 1'b1;
        w_bankidx_nxt      = w_bank;
      end else begin
        case (w_op)
          3'b000: w_mrw = 1'b1;
          3'b001: begin
            if (r_openbanks != '0) w_cmd_err = 1'b1;
            else                   w_ref     = 1'b1;
          end
          3'b010: begin
            if (A[10]) begin
              w_pra      = '1;
              w_open_nxt = '0;
            end else begin
              w_pr[w_bank]       = 1'b1;
              w_open_nxt[w_bank] = 1'b0;
              w_bankidx_nxt      = w_bank;
            end
          end
          3'b100, 3'b101: begin
            if (r_openbanks[w_bank]) begin
              w_bankidx_nxt = w_bank;
              w_coladdr_nxt = A[9:0];
              w_rowaddr_nxt = r_row[w_bank];
              if (A[10]) w_open_nxt[w_bank] = 1'b0;
              case ({w_op[0], A[10]})
                2'b00:   w_wr[w_bank]  = 1'b1;
                2'b01:   w_wra[w_bank] = 1'b1;
                2'b10:   w_rd[w_bank]  = 1'b1;
                default: w_rda[w_bank] = 1'b1;
              endcase
            end else begin
              w_cmd_err = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Output, bookkeeping and power-state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= PS_ACTIVE;
      r_cke_q     <= 1'b1;
      r_act       <= '0;
      r_rd        <= '0;
      r_rda       <= '0;
      r_wr        <= '0;
      r_wra       <= '0;
      r_pr        <= '0;
      r_pra       <= '0;
      r_ref       <= 1'b0;
      r_srf       <= 1'b0;
      r_pd        <= 1'b0;
      r_pdx       <= 1'b0;
      r_ckeh      <= 1'b0;
      r_ckel      <= 1'b0;
      r_mrw       <= 1'b0;
      r_err       <= 1'b0;
      r_bankidx   <= '0;
      r_rowaddr   <= '0;
      r_coladdr   <= '0;
      r_openbanks <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cke_q     <= cke;
      r_act       <= w_act;
      r_rd        <= w_rd;
      r_rda       <= w_rda;
      r_wr        <= w_wr;
      r_wra       <= w_wra;
      r_pr        <= w_pr;
      r_pra       <= w_pra;
      r_ref       <= w_ref;
      r_srf       <= w_srf;
      r_pd        <= w_pd;
      r_pdx       <= w_pdx;
      r_ckeh      <= w_ckeh;
      r_ckel      <= w_ckel;
      r_mrw       <= w_mrw;
      r_err       <= w_cmd_err | w_pwr_err;
      r_bankidx   <= w_bankidx_nxt;
      r_rowaddr   <= w_rowaddr_nxt;
      r_coladdr   <= w_coladdr_nxt;
      r_openbanks <= w_open_nxt;
    end
  end

  // Per-bank active row storage, written by ACT
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NB; i++) r_row[i] <= '0;
    end else if (w_row_we) begin
      r_row[w_bank] <= A;
    end
  end

  assign ACT       = r_act;
  assign RD        = r_rd;
  assign RDA       = r_rda;
  assign WR        = r_wr;
  assign WRA       = r_wra;
  assign PR        = r_pr;
  assign PRA       = r_pra;
  assign REF       = r_ref;
  assign SRF       = r_srf;
  assign PD        = r_pd;
  assign PDX       = r_pdx;
  assign CKEH      = r_ckeh;
  assign CKEL      = r_ckel;
  assign MRW       = r_mrw;
  assign cmd_err   = r_err;
  assign bankidx   = r_bankidx;
  assign rowaddr   = r_rowaddr;
  assign coladdr   = r_coladdr;
  assign openbanks = r_openbanks;
  assign pstate    = r_state;

endmodule

// File: tb/tb_ddr_cmd_decoder.sv
// Bench for ddr_cmd_decoder: directed scenarios from the command rules
// plus a randomized run checked against a command-level reference model.
module tb_ddr_cmd_decoder;

  // Clock / reset / pins
  logic        clk = 1'b0;
  logic        rst, cke, cs_n, act_n;
  logic [1:0]  bg, ba;
  logic [16:0] A;
  logic [15:0] ACT, RD, RDA, WR, WRA, PR, PRA, openbanks;
  logic        REF, SRF, PD, PDX, CKEH, CKEL, MRW, cmd_err;
  logic [3:0]  bankidx;
  logic [16:0] rowaddr;
  logic [9:0]  coladdr;
  logic [1:0]  pstate;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ddr_cmd_decoder dut (
    .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .act_n(act_n),
    .bg(bg), .ba(ba), .A(A),
    .ACT(ACT), .RD(RD), .RDA(RDA), .WR(WR), .WRA(WRA), .PR(PR), .PRA(PRA),
    .REF(REF), .SRF(SRF), .PD(PD), .PDX(PDX), .CKEH(CKEH), .CKEL(CKEL),
    .MRW(MRW), .bankidx(bankidx), .rowaddr(rowaddr), .coladdr(coladdr),
    .openbanks(openbanks), .pstate(pstate), .cmd_err(cmd_err)
  );

  // Observation bundles
  logic [168:0] w_obs;
  logic [119:0] w_strb;
  assign w_strb = {ACT, RD, RDA, WR, WRA, PR, PRA, REF, SRF, PD, PDX, CKEH, CKEL, MRW, cmd_err};
  assign w_obs  = {w_strb, bankidx, rowaddr, coladdr, openbanks, pstate};

  // Reference model: command-level view of the rank
  logic        m_cke_q;
  logic [1:0]  m_ps;
  logic [15:0] m_open;
  logic [16:0] m_row [16];
  logic [3:0]  m_bidx;
  logic [16:0] m_raddr;
  logic [9:0]  m_col;
  logic [15:0] m_act, m_rd, m_rda, m_wr, m_wra, m_pr, m_pra;
  logic        m_ref, m_srf, m_pd, m_pdx, m_ckeh, m_ckel, m_mrw, m_err;

  function automatic string classify(logic valid, logic an, logic [16:0] a);
    if (!valid) return "NONE";
    if (!an) return "ACT";
    case (a[16:14])
      3'd0: return "MRS";
      3'd1: return "REF";
      3'd2: return a[10] ? "PREA" : "PRE";
      3'd4: return a[10] ? "WRA" : "WR";
      3'd5: return a[10] ? "RDA" : "RD";
      3'd7: return "NOP";
      default: return "RFU";
    endcase
  endfunction

  function automatic logic [168:0] exp_bundle();
    return {m_act, m_rd, m_rda, m_wr, m_wra, m_pr, m_pra, m_ref, m_srf, m_pd,
            m_pdx, m_ckeh, m_ckel, m_mrw, m_err, m_bidx, m_raddr, m_col, m_open, m_ps};
  endfunction

  task automatic model_update();
    string nm;
    logic  fall, rise, valid;
    int    b;
    {m_act, m_rd, m_rda, m_wr, m_wra, m_pr, m_pra} = '0;
    {m_ref, m_srf, m_pd, m_pdx, m_ckeh, m_ckel, m_mrw, m_err} = '0;
    if (rst) begin
      m_cke_q = 1'b1; m_ps = 2'd0; m_open = '0; m_bidx = '0; m_raddr = '0; m_col = '0;
      for (int i = 0; i < 16; i++) m_row[i] = '0;
      return;
    end
    fall  = m_cke_q && !cke;
    rise  = !m_cke_q && cke;
    valid = !cs_n && m_cke_q;
    nm    = classify(valid, act_n, A);
    b     = int'({bg, ba});
    if (m_ps == 2'd0 && fall) begin
      m_ckel = 1'b1;
      if (nm == "REF" && m_open == 16'h0) begin
        m_ps = 2'd2; m_srf = 1'b1;
      end else begin
        m_ps = 2'd1; m_pd = 1'b1;
        m_err = !(nm == "NONE" || nm == "NOP");
      end
    end else if (m_ps == 2'd1 && rise) begin
      m_ps = 2'd0; m_pdx = 1'b1; m_ckeh = 1'b1;
    end else if (m_ps == 2'd2 && rise) begin
      m_ps = 2'd0; m_ckeh = 1'b1;
    end else if (m_ps == 2'd0 && valid) begin
      if (nm == "ACT") begin
        m_act[b] = 1'b1; m_open[b] = 1'b1; m_row[b] = A; m_bidx = 4'(b);
      end else if (nm == "MRS") begin
        m_mrw = 1'b1;
      end else if (nm == "REF") begin
        if (m_open != 16'h0) m_err = 1'b1; else m_ref = 1'b1;
      end else if (nm == "PRE") begin
        m_pr[b] = 1'b1; m_open[b] = 1'b0; m_bidx = 4'(b);
      end else if (nm == "PREA") begin
        m_pra = 16'hFFFF; m_open = 16'h0;
      end else if (nm == "RD" || nm == "RDA" || nm == "WR" || nm == "WRA") begin
        if (!m_open[b]) begin
          m_err = 1'b1;
        end else begin
          if (nm == "RD")  m_rd[b]  = 1'b1;
          if (nm == "RDA") m_rda[b] = 1'b1;
          if (nm == "WR")  m_wr[b]  = 1'b1;
          if (nm == "WRA") m_wra[b] = 1'b1;
          m_col = A[9:0]; m_raddr = m_row[b]; m_bidx = 4'(b);
          if (nm == "RDA" || nm == "WRA") m_open[b] = 1'b0;
        end
      end
    end
    m_cke_q = cke;
  endtask

  // Driver tasks
  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] mk_a(logic [2:0] op, logic a10, logic [9:0] col);
    return {op, 3'b000, a10, col};
  endfunction

  task automatic cmd(logic k, logic csn, logic an, logic [3:0] bank, logic [16:0] addr);
    cke = k; cs_n = csn; act_n = an; {bg, ba} = bank; A = addr;
    tick();
  endtask

  task automatic nop(logic k);
    cmd(k, 1'b0, 1'b1, 4'd0, mk_a(3'd7, 1'b0, 10'd0));
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1'b1; nop(1'b1); nop(1'b1);
    n_total++;
    if (w_obs !== '0) $display("FAIL reset_state: got %h want 0", w_obs); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_act_rd();
    cmd(1'b1, 1'b0, 1'b0, 4'd5, 17'h01234);
    n_total++;
    if ({ACT, openbanks} !== {16'h0020, 16'h0020})
      $display("FAIL act_strobe: got %h/%h want 0020/0020", ACT, openbanks);
    else n_pass++;
    cmd(1'b1, 1'b0, 1'b1, 4'd5, mk_a(3'd5, 1'b0, 10'd7));
    n_total++;
    if ({RD, rowaddr, coladdr, bankidx} !== {16'h0020, 17'h01234, 10'd7, 4'd5})
      $display("FAIL rd_strobe: got %h/%h/%h/%h want 0020/01234/007/5", RD, rowaddr, coladdr, bankidx);
    else n_pass++;
  endtask

  task automatic test_rda();
    cmd(1'b1, 1'b0, 1'b1, 4'd5, mk_a(3'd5, 1'b1, 10'd9));
    n_total++;
    if ({RDA, RD, openbanks} !== {16'h0020, 16'h0000, 16'h0000})
      $display("FAIL rda_close: got %h/%h/%h want 0020/0000/0000", RDA, RD, openbanks);
    else n_pass++;
  endtask

  task automatic test_rd_closed();
    cmd(1'b1, 1'b0, 1'b1, 4'd3, mk_a(3'd5, 1'b0, 10'd1));
    n_total++;
    if ({RD, cmd_err} !== {16'h0000, 1'b1})
      $display("FAIL rd_closed: got rd=%h err=%b want 0000/1", RD, cmd_err);
    else n_pass++;
    nop(1'b1);
    n_total++;
    if (cmd_err !== 1'b0) $display("FAIL err_width: got %b want 0", cmd_err); else n_pass++;
  endtask

  task automatic test_prea();
    cmd(1'b1, 1'b0, 1'b0, 4'd0, 17'h00011);
    cmd(1'b1, 1'b0, 1'b0, 4'd7, 17'h00077);
    cmd(1'b1, 1'b0, 1'b0, 4'd15, 17'h000FF);
    n_total++;
    if (openbanks !== 16'h8081) $display("FAIL open_three: got %h want 8081", openbanks); else n_pass++;
    cmd(1'b1, 1'b0, 1'b1, 4'd2, mk_a(3'd2, 1'b1, 10'd0));
    n_total++;
    if ({PRA, PR, openbanks} !== {16'hFFFF, 16'h0000, 16'h0000})
      $display("FAIL prea: got %h/%h/%h want ffff/0000/0000", PRA, PR, openbanks);
    else n_pass++;
  endtask

  task automatic test_ref_open();
    cmd(1'b1, 1'b0, 1'b0, 4'd2, 17'h00abc);
    cmd(1'b1, 1'b0, 1'b1, 4'd0, mk_a(3'd1, 1'b0, 10'd0));
    n_total++;
    if ({REF, cmd_err} !== 2'b01) $display("FAIL ref_open: got ref=%b err=%b want 0/1", REF, cmd_err); else n_pass++;
    cmd(1'b1, 1'b0, 1'b1, 4'd2, mk_a(3'd2, 1'b0, 10'd0));
    n_total++;
    if ({PR, openbanks} !== {16'h0004, 16'h0000})
      $display("FAIL pre_bank: got %h/%h want 0004/0000", PR, openbanks);
    else n_pass++;
    cmd(1'b1, 1'b0, 1'b1, 4'd0, mk_a(3'd1, 1'b0, 10'd0));
    n_total++;
    if ({REF, cmd_err} !== 2'b10) $display("FAIL ref_closed: got ref=%b err=%b want 1/0", REF, cmd_err); else n_pass++;
  endtask

  task automatic test_power();
    cmd(1'b0, 1'b0, 1'b1, 4'd0, mk_a(3'd1, 1'b0, 10'd0));
    n_total++;
    if ({SRF, CKEL, REF, pstate} !== {1'b1, 1'b1, 1'b0, 2'd2})
      $display("FAIL sre: got srf=%b ckel=%b ref=%b ps=%0d want 1/1/0/2", SRF, CKEL, REF, pstate);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      cmd(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom), 17'($urandom));
      n_total++;
      if ({w_strb, pstate} !== {120'd0, 2'd2})
        $display("FAIL selfref_quiet: got strb=%h ps=%0d want 0/2", w_strb, pstate);
      else n_pass++;
    end
    nop(1'b1);
    n_total++;
    if ({CKEH, PDX, pstate} !== {1'b1, 1'b0, 2'd0})
      $display("FAIL srx: got ckeh=%b pdx=%b ps=%0d want 1/0/0", CKEH, PDX, pstate);
    else n_pass++;
    nop(1'b0);
    n_total++;
    if ({PD, CKEL, cmd_err, pstate} !== {1'b1, 1'b1, 1'b0, 2'd1})
      $display("FAIL pde: got pd=%b ckel=%b err=%b ps=%0d want 1/1/0/1", PD, CKEL, cmd_err, pstate);
    else n_pass++;
    nop(1'b0);
    nop(1'b1);
    n_total++;
    if ({PDX, CKEH, pstate} !== {1'b1, 1'b1, 2'd0})
      $display("FAIL pdx: got pdx=%b ckeh=%b ps=%0d want 1/1/0", PDX, CKEH, pstate);
    else n_pass++;
    cmd(1'b0, 1'b0, 1'b1, 4'd1, mk_a(3'd0, 1'b0, 10'd0));
    n_total++;
    if ({PD, MRW, cmd_err, pstate} !== {1'b1, 1'b0, 1'b1, 2'd1})
      $display("FAIL pde_cmd: got pd=%b mrw=%b err=%b ps=%0d want 1/0/1/1", PD, MRW, cmd_err, pstate);
    else n_pass++;
    nop(1'b1);
  endtask

  task automatic test_reset_mid();
    cmd(1'b0, 1'b0, 1'b1, 4'd0, mk_a(3'd1, 1'b0, 10'd0));
    nop(1'b0);
    rst = 1'b1;
    cmd(1'b1, 1'b0, 1'b0, 4'd4, 17'h00555);
    n_total++;
    if ({pstate, openbanks, CKEH, ACT} !== {2'd0, 16'h0, 1'b0, 16'h0})
      $display("FAIL reset_mid: got ps=%0d open=%h ckeh=%b act=%h want 0/0/0/0", pstate, openbanks, CKEH, ACT);
    else n_pass++;
    rst = 1'b0;
    nop(1'b1);
    n_total++;
    if ({CKEH, PD, pstate} !== {1'b0, 1'b0, 2'd0})
      $display("FAIL reset_after: got ckeh=%b pd=%b ps=%0d want 0/0/0", CKEH, PD, pstate);
    else n_pass++;
  endtask

  task automatic test_random();
    logic        k = 1'b1;
    logic [2:0]  op;
    logic [16:0] a;
    int          r;
    logic [168:0] e;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 11) == 0) k = ~k;
      r = $urandom_range(0, 9);
      case (r)
        0:       op = 3'd0;
        1:       op = 3'd1;
        2, 3:    op = 3'd2;
        4, 5:    op = 3'd4;
        6, 7:    op = 3'd5;
        8:       op = 3'd7;
        default: op = $urandom_range(0, 1) ? 3'd3 : 3'd6;
      endcase
      a = {op, 14'($urandom)};
      a[10] = ($urandom_range(0, 3) == 0);
      cmd(k, ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0), 4'($urandom), a);
      e = exp_bundle();
      n_total++;
      if (w_obs !== e) $display("FAIL random_%0d: got %h want %h", i, w_obs, e);
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cke = 1'b1; cs_n = 1'b1; act_n = 1'b1; bg = '0; ba = '0; A = '0;
    test_reset();
    test_act_rd();
    test_rda();
    test_rd_closed();
    test_prea();
    test_ref_open();
    test_power();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/ddr_cmd_decoder.md
# ddr_cmd_decoder

Decodes the raw DDR4 command/address bus of one rank into the per-bank one-cycle command strobes that drive the per-bank `memtiming` FSMs, and into rank-wide strobes for refresh, power-down and mode-register writes. Sits directly upstream of the bank FSM array: host/PHY pins in, strobes out. It also tracks which banks are open, latches the active row per bank, flags illegal commands, and runs the rank power-state machine from CKE edges.

## Interface
- `BGWIDTH`, 2, bank-group address bits.
- `BAWIDTH`, 2, bank address bits.
- `ADDRWIDTH`, 17, address bus width. Fixed at 17: A16/A15/A14 double as RAS_n/CAS_n/WE_n.
- `NB` (localparam), 2^(BGWIDTH+BAWIDTH), bank count; bank index = {bg, ba}.

- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `cke` in 1: clock enable pin.
- `cs_n` in 1: chip select, active low.
- `act_n` in 1: activate, active low.
- `bg` in BGWIDTH: bank group.
- `ba` in BAWIDTH: bank.
- `A` in ADDRWIDTH: address; A10 = auto-precharge / all-banks bit.
- `ACT`, `RD`, `RDA`, `WR`, `WRA`, `PR`, `PRA` out NB each: per-bank one-cycle strobes.
- `REF`, `SRF`, `PD`, `PDX`, `CKEH`, `CKEL`, `MRW` out 1 each: rank-wide one-cycle strobes, fanned out to all FSMs.
- `bankidx` out BGWIDTH+BAWIDTH: bank of the last decoded bank command.
- `rowaddr` out ADDRWIDTH: latched row of `bankidx`.
- `coladdr` out 10: A[9:0] of the last RD/WR.
- `openbanks` out NB: open-row bitmap.
- `pstate` out 2: 0 ACTIVE, 1 PWRDN, 2 SELFREF.
- `cmd_err` out 1: one-cycle pulse on an illegal command.

## Operation
- **Command-valid condition:** a command is valid only when `cs_n`=0 and `cke_q`=1, where `cke_q` is `cke` registered.
- **Decode when `act_n`=0:** ACTIVATE; the row is the full `A`.
- **Decode when `act_n`=1**, keyed on {A16,A15,A14}:
  - 000: MRS → `MRW`.
  - 001: REF.
  - 010: PRE; A10=1 → PREA.
  - 100: WR; A10=1 → WRA.
  - 101: RD; A10=1 → RDA.
  - 011, 110: ignored (RFU, ZQ).
  - 111: NOP.
- **ACT:**
  - `ACT[b]` pulses.
  - `openbanks[b]` is set.
  - `row[b]` ← `A`.
  - ACT to an already-open bank is forwarded unchanged; the FSM treats it as RowClone.
- **RD/RDA/WR/WRA:**
  - Strobe on bank b.
  - `coladdr` ← A[9:0].
  - `rowaddr` ← `row[b]`.
  - RDA/WRA also clear `openbanks[b]`.
  - If bank b is closed, the strobe is suppressed and `cmd_err` pulses.
- **PRE:** `PR[b]` pulses and `openbanks[b]` is cleared. PRE to a closed bank is legal (no error).
- **PREA:** `PRA` pulses on all NB bits and `openbanks` is cleared to 0.
- **REF:**
  - With any bank open: suppressed, and `cmd_err` pulses.
  - With all banks closed: `REF` pulses.
- **Power-state FSM** (`cke` edges are derived from `cke_q`):
  - **ACTIVE, falling edge with a valid REF and all banks closed:** → SELFREF; pulse `SRF` and `CKEL`; `REF` does not pulse.
  - **ACTIVE, falling edge with a NOP/deselect:** → PWRDN; pulse `PD` and `CKEL`.
  - **ACTIVE, falling edge with any other command:** → PWRDN; pulse `PD`, `CKEL` and `cmd_err`; the command is dropped.
  - **PWRDN, rising edge:** → ACTIVE; pulse `PDX` and `CKEH`.
  - **SELFREF, rising edge:** → ACTIVE; pulse `CKEH`.
  - **While `cke_q`=0:** the command bus is ignored.
- **Simultaneous events:** at most one command per cycle by construction. A strobe and a power transition can coincide only as defined above.

## Timing
- **Latency:** exactly 1 cycle. A strobe is high in cycle N+1 for a command sampled at edge N.
- **Pulse width:** every strobe and `cmd_err` is high for exactly 1 cycle. Back-to-back commands give back-to-back pulses.
- **State-output update:** `openbanks`, `rowaddr`, `coladdr`, `bankidx` and `pstate` update in the same cycle as the corresponding strobe.
- **Reset values:**
  - All strobes, `cmd_err`, `openbanks`, `bankidx`, `rowaddr` and `coladdr` are 0.
  - All `row[]` entries are 0.
  - `pstate` = ACTIVE.
  - `cke_q` = 1, so no spurious edge occurs after reset.
- **Reset mid-operation:**
  - `rst` during SELFREF or PWRDN returns `pstate` to ACTIVE and clears `openbanks` on the next edge.
  - No `PDX`/`CKEH` is emitted.
  - A command sampled on the reset edge is discarded.

## Test plan
- **ACT then RD:** ACT bg=1 ba=1 A=0x1234, then RD bank 5 A=0x0007.
  - Cycle+1: `ACT`=0x0020; `openbanks`=0x0020.
  - Next cycle: `RD`=0x0020, `rowaddr`=0x1234, `coladdr`=7.
- **RDA closes the bank:** from the previous state, RD on bank 5 with A10=1 → `RDA`=0x0020; `openbanks`=0.
- **Read to a closed bank:** RD to bank 3 with `openbanks`=0 → `RD`=0; `cmd_err`=1 for one cycle.
- **PREA:** open banks 0, 7 and 15, then PRE with A10=1 → `PRA`=0xFFFF; `openbanks`=0.
- **Self-refresh and power-down round trip:** with all banks closed:
  - REF with `cke` falling → `SRF`=1, `CKEL`=1, `REF`=0, `pstate`=2.
  - Hold `cke`=0 for 10 cycles: no strobes.
  - Raise `cke` → `CKEH`=1, `pstate`=0.
  - Then NOP with `cke` falling → `PD`=1, `pstate`=1; raise `cke` → `PDX`=1.
- **Reset mid-operation:** assert `rst` while in SELFREF with a stale `openbanks` → next cycle `pstate`=0, `openbanks`=0, no `CKEH` pulse.
